mpsk_symbol_mapper: RTL

//  Parametrised M-PSK mapper for the DDS modulator path: BPSK/QPSK/8PSK, Gray-coded.

---
 rtl/mpsk_symbol_mapper.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mpsk_symbol_mapper.sv
// Gray-coded BPSK/QPSK/8PSK mapper: packs a serial bit stream into symbols and
// emits a DDS phase word on each symbol tick, flagging ticks that find no symbol staged.
module mpsk_symbol_mapper #(
    parameter int                  PHASE_W      = 16,
    parameter int                  FREQ_W       = 16,
    parameter int                  SYM_CNT_W    = 16,
    parameter logic [PHASE_W-1:0]  PHASE_OFFSET = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [SYM_CNT_W-1:0] sym_period,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    input  logic [FREQ_W-1:0]    freq_in,
    output logic [FREQ_W-1:0]    freq_out,
    output logic [PHASE_W-1:0]   phase_out,
    output logic                 sym_strobe,
    output logic                 underrun,
    output logic [1:0]           fsm_state
);

    // Handshake: a bit transfers on a rising clk edge when bit_valid & bit_ready are both high;
    // bit_ready depends only on enable and registered state, never on bit_valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [1:0]           bit_cnt, bit_cnt_nxt;
    logic [1:0]           sym_k, sym_k_nxt;
    logic [2:0]           sreg, sreg_nxt;
    logic [SYM_CNT_W-1:0] sym_cnt;
    logic [SYM_CNT_W-1:0] period_m1;
    logic                 tick;
    logic                 accept;
    logic [1:0]           mode_k;
    logic [1:0]           k_cur;
    logic [2:0]           sym_bin;
    logic [PHASE_W-1:0]   sym_phase;
    logic                 load_phase;
    logic                 underrun_nxt;

    assign mode_k    = (mode == 2'b01) ? 2'd2 : (mode == 2'b10) ? 2'd3 : 2'd1;
    assign bit_ready = enable & (state == FILL);
    assign accept    = bit_valid & bit_ready;
    assign k_cur     = (bit_cnt == 2'd0) ? mode_k : sym_k;
    assign fsm_state = state;

    // A zero period behaves as one clock per symbol.
    assign period_m1 = (sym_period == '0) ? '0 : sym_period - 1'b1;
    assign tick      = enable & (sym_cnt >= period_m1);

    // Staged bits sit right-aligned with zero fill, so one prefix-XOR serves every k.
    assign sym_bin   = {sreg[2], sreg[2] ^ sreg[1], sreg[2] ^ sreg[1] ^ sreg[0]};
    assign sym_phase = PHASE_OFFSET + (PHASE_W'(sym_bin) << (PHASE_W - 32'(sym_k)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt <= '0;
        end else if (!enable || tick) begin
            sym_cnt <= '0;
        end else begin
            sym_cnt <= sym_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        sym_k_nxt    = sym_k;
        sreg_nxt     = sreg;
        load_phase   = 1'b0;
        underrun_nxt = 1'b0;
        if (!enable) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = 2'd0;
            sym_k_nxt   = 2'd1;
            sreg_nxt    = 3'd0;
        end else begin
            case (state)
                IDLE: state_nxt = FILL;
                FILL: begin
                    underrun_nxt = tick;
                    if (accept) begin
                        if (bit_cnt == 2'd0) begin
                            sym_k_nxt = mode_k;
                            sreg_nxt  = {2'b00, bit_in};
                        end else begin
                            sreg_nxt  = {sreg[1:0], bit_in};
                        end
                        if (bit_cnt + 2'd1 == k_cur) begin
                            state_nxt   = FULL;
                            bit_cnt_nxt = 2'd0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 2'd1;
                        end
                    end
                end
                FULL: begin
                    if (tick) begin
                        load_phase = 1'b1;
                        state_nxt  = FILL;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= 2'd0;
            sym_k      <= 2'd1;
            sreg       <= 3'd0;
            phase_out  <= PHASE_OFFSET;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            freq_out   <= '0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            sym_k      <= sym_k_nxt;
            sreg       <= sreg_nxt;
            sym_strobe <= load_phase;
            underrun   <= underrun_nxt;
            freq_out   <= freq_in;
            if (load_phase) begin
                phase_out <= sym_phase;
            end
        end
    end

endmodule
